// File: rtl/posit_field_decode_if.sv
// ============================================================================
// Module   : posit_field_decode_if
// Brief    : Valid/ready bundle between the seed extractor, field decoder and
//            the arithmetic datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface posit_field_decode_if #(
    parameter int BITS   = 32,
    parameter int ES     = 2,
    parameter int FRAC_W = BITS - ES - 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BITS-1:0]        in_posit;
    logic signed [BITS-1:0] in_seed;
    logic [BITS-1:0]        in_shifted;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sign;
    logic signed [BITS-1:0] out_scale;
    logic [FRAC_W:0]        out_frac;
    logic                   out_zero;
    logic                   out_nar;

    // Producer/consumer side (bench or surrounding pipeline).
    modport master (
        output in_valid, in_posit, in_seed, in_shifted, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_posit, in_seed, in_shifted, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );
endinterface

`default_nettype wire

// File: rtl/posit_field_decode.sv
// ============================================================================
// Module   : posit_field_decode
// Brief    : Two-stage pipeline turning regime seed + stripped remainder into
//            sign / scale / hidden-bit fraction with zero and NaR flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module posit_field_decode #(
    parameter int BITS   = 32,
    parameter int ES     = 2,
    parameter int FRAC_W = BITS - ES - 3
) (
    input  wire                 clk,
    input  wire                 rst,
    posit_field_decode_if.slave bus
);
    localparam int c_BODY_W = ES + FRAC_W;

    // Stage 1 keeps only the remainder bits that carry exponent + fraction.
    logic                   r_s1_valid;
    logic                   r_s1_sign;
    logic                   r_s1_zero;
    logic                   r_s1_nar;
    logic signed [BITS-1:0] r_s1_seed;
    logic [c_BODY_W-1:0]    r_s1_body;

    logic                   r_s2_valid;
    logic                   r_s2_sign;
    logic signed [BITS-1:0] r_s2_scale;
    logic [FRAC_W:0]        r_s2_frac;
    logic                   r_s2_zero;
    logic                   r_s2_nar;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_special;
    logic signed [BITS-1:0] w_exp;
    logic signed [BITS-1:0] w_scale;
    logic [FRAC_W:0]        w_frac;

    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    generate
        if (ES > 0) begin : g_exp
            assign w_exp = {{(BITS-ES){1'b0}}, r_s1_body[c_BODY_W-1 -: ES]};
        end else begin : g_no_exp
            assign w_exp = '0;
        end
    endgenerate

    assign w_special = r_s1_zero || r_s1_nar;
    assign w_scale   = w_special ? '0 : (r_s1_seed <<< ES) + w_exp;
    assign w_frac    = w_special ? '0 : {1'b1, r_s1_body[FRAC_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_seed  <= '0;
            r_s1_body  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_scale <= '0;
            r_s2_frac  <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_nar   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_sign <= bus.in_posit[BITS-1];
                    r_s1_zero <= (bus.in_posit == '0);
                    r_s1_nar  <= (bus.in_posit == {1'b1, {(BITS-1){1'b0}}});
                    r_s1_seed <= bus.in_seed;
                    r_s1_body <= bus.in_shifted[BITS-1 -: c_BODY_W];
                end
            end
            // Stage 2 registers only move on a real S1->S2 transfer so outputs hold under stall.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_sign  <= r_s1_sign;
                    r_s2_scale <= w_scale;
                    r_s2_frac  <= w_frac;
                    r_s2_zero  <= r_s1_zero;
                    r_s2_nar   <= r_s1_nar;
                end
            end
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_sign  = r_s2_sign;
    assign bus.out_scale = r_s2_scale;
    assign bus.out_frac  = r_s2_frac;
    assign bus.out_zero  = r_s2_zero;
    assign bus.out_nar   = r_s2_nar;

endmodule

`default_nettype wire

// File: tb/tb_posit_field_decode.sv
// ============================================================================
// Module   : tb_posit_field_decode
// Brief    : Directed self-checking bench for posit_field_decode (BITS=32, ES=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_posit_field_decode;
    localparam int BITS   = 32;
    localparam int ES     = 2;
    localparam int FRAC_W = BITS - ES - 3;
    localparam logic [31:0] c_HIDDEN = 32'h0800_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    posit_field_decode_if #(.BITS(BITS), .ES(ES), .FRAC_W(FRAC_W)) bus ();

    posit_field_decode #(.BITS(BITS), .ES(ES), .FRAC_W(FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input int seed, input logic [31:0] sh);
        bus.in_valid   = v;
        bus.in_posit   = p;
        bus.in_seed    = seed;
        bus.in_shifted = sh;
    endtask

    task automatic check_out(input string tag, input logic sign, input int scale,
                             input logic [31:0] frac, input logic zero, input logic nar);
        check({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, ".sign"},  {31'b0, bus.out_sign},  {31'b0, sign});
        check({tag, ".scale"}, bus.out_scale,          scale);
        check({tag, ".frac"},  {4'b0, bus.out_frac},   frac);
        check({tag, ".zero"},  {31'b0, bus.out_zero},  {31'b0, zero});
        check({tag, ".nar"},   {31'b0, bus.out_nar},   {31'b0, nar});
    endtask

    // One isolated word: out_valid low after one edge, result present after the second.
    task automatic single(input string tag, input logic [31:0] p, input int seed,
                          input logic [31:0] sh, input logic sign, input int scale,
                          input logic [31:0] frac, input logic zero, input logic nar);
        drive(1'b1, p, seed, sh);
        step();
        drive(1'b0, 32'hDEAD_BEEF, -7, 32'hFFFF_FFFF);
        check({tag, ".lat1"}, {31'b0, bus.out_valid}, 32'd0);
        step();
        check_out(tag, sign, scale, frac, zero, nar);
        step();
        check({tag, ".drain"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(1'b0, '0, 0, '0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst.sign",      {31'b0, bus.out_sign},  32'd0);
        check("rst.scale",     bus.out_scale,          32'd0);
        check("rst.frac",      {4'b0, bus.out_frac},   32'd0);
        check("rst.zero",      {31'b0, bus.out_zero},  32'd0);
        check("rst.nar",       {31'b0, bus.out_nar},   32'd0);
        check("rst.in_ready",  {31'b0, bus.in_ready},  32'd1);

        single("one",    32'h4000_0000, 0,  32'h0000_0000, 1'b0, 0,   c_HIDDEN, 1'b0, 1'b0);
        single("negk",   32'h0C00_0000, -3, 32'h8000_0000, 1'b0, -10, c_HIDDEN, 1'b0, 1'b0);
        single("zero",   32'h0000_0000, -30, 32'hFFFF_FFF8, 1'b0, 0,  32'd0,    1'b1, 1'b0);
        single("nar",    32'h8000_0000, 30, 32'hFFFF_FFF8, 1'b1, 0,   32'd0,    1'b0, 1'b1);
        single("allfr",  32'h7000_0000, 2,  32'h7FFF_FFF8, 1'b0, 9,   32'h0FFF_FFFF, 1'b0, 1'b0);
        single("negsgn", 32'hC000_0000, 0,  32'h0000_0000, 1'b1, 0,   c_HIDDEN, 1'b0, 1'b0);

        // Streaming: word i has seed i, exponent i&3, fraction LSBs i.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 32'h4000_0000 + k, k, (k << 30) | (k << 3));
            else       drive(1'b0, '0, 0, '0);
            check("stream.in_ready", {31'b0, bus.in_ready}, 32'd1);
            step();
            if (k >= 1 && k <= 8) begin
                check("stream.valid", {31'b0, bus.out_valid}, 32'd1);
                check("stream.scale", bus.out_scale, 4 * (k - 1) + ((k - 1) & 3));
                check("stream.frac",  {4'b0, bus.out_frac}, c_HIDDEN | (k - 1));
            end else begin
                check("stream.bubble", {31'b0, bus.out_valid}, 32'd0);
            end
        end

        // Backpressure: A, B fill both stages; C waits.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h5000_0000, 1, 32'h0);
        check("bp.rdyA", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive(1'b1, 32'h6000_0000, 2, 32'h0);
        check("bp.rdyB", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive(1'b1, 32'h6800_0000, 3, 32'h0);
        for (int c = 0; c < 4; c++) begin
            check("bp.stall_rdy",   {31'b0, bus.in_ready},  32'd0);
            check("bp.stall_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp.stall_scale", bus.out_scale, 4);
            check("bp.stall_frac",  {4'b0, bus.out_frac}, c_HIDDEN);
            if (c < 3) step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_rdy", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive(1'b0, '0, 0, '0);
        check("bp.outB_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp.outB_scale", bus.out_scale, 8);
        step();
        check("bp.outC_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp.outC_scale", bus.out_scale, 12);
        step();
        check("bp.empty", {31'b0, bus.out_valid}, 32'd0);

        // Reset with both stages full discards everything.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h5000_0000, 5, 32'h0);
        step();
        drive(1'b1, 32'h5000_0000, 6, 32'h0);
        step();
        check("rmid.full", {31'b0, bus.out_valid}, 32'd1);
        drive(1'b0, '0, 0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rmid.valid", {31'b0, bus.out_valid}, 32'd0);
        check("rmid.ready", {31'b0, bus.in_ready},  32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            check("rmid.no_stale", {31'b0, bus.out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
